// File: rtl/ibex_mem_arbiter_if.sv
// Bus bundle between the Ibex instr/data OBI ports, the arbiter and the single-port RAM.
// The arbiter takes the slave view; the core/RAM environment takes the master view.
interface ibex_mem_arbiter_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    logic        mem_req;
    logic        mem_write;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output mem_req, mem_write, mem_be, mem_addr, mem_wdata,
        input  mem_rvalid, mem_rdata
    );

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  mem_req, mem_write, mem_be, mem_addr, mem_wdata,
        output mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// Instr/data arbiter in front of one single-port RAM, instr priority with data-starvation override.
// ARB_PERF_CNT_EN adds grant/conflict performance counters.
//   state     | meaning
//   PRI_INSTR | instr wins a simultaneous request; data refusals are counted
//   PRI_DATA  | data starved for STARVE_LIMIT cycles, data wins until granted
module ibex_mem_arbiter #(
    parameter logic [31:0] MEM_START    = 32'h0000_0000,
    parameter int unsigned MEM_SIZE     = 65536,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    ibex_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       instr_gnt_cnt,
    output logic [31:0]       data_gnt_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    localparam logic [31:0] MEM_MASK = 32'(MEM_SIZE - 1);
    localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

    typedef enum logic {
        PRI_INSTR = 1'b0,
        PRI_DATA  = 1'b1
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       pend_instr_q, pend_instr_d;
    logic       pend_data_q, pend_data_d;
    logic       pend_err_q, pend_err_d;

    logic instr_win, data_win;
    logic instr_in_range, data_in_range;

    assign instr_in_range = (bus.instr_addr & ~MEM_MASK) == MEM_START;
    assign data_in_range  = (bus.data_addr & ~MEM_MASK) == MEM_START;

    // Grants are held off during reset so every output reads 0 while rst_sys is high.
    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (!rst_sys) begin
            if (state_q == PRI_DATA) begin
                data_win  = bus.data_req;
                instr_win = bus.instr_req & ~bus.data_req;
            end else begin
                instr_win = bus.instr_req;
                data_win  = bus.data_req & ~bus.instr_req;
            end
        end
    end

    assign bus.instr_gnt = instr_win;
    assign bus.data_gnt  = data_win;

    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (instr_win && instr_in_range) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = bus.instr_addr;
        end else if (data_win && data_in_range) begin
            bus.mem_req   = 1'b1;
            bus.mem_write = bus.data_we;
            bus.mem_be    = bus.data_be;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (!bus.data_req || data_win) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        case (state_q)
            PRI_INSTR: if (starve_cnt_d == LIMIT) state_d = PRI_DATA;
            PRI_DATA:  if (data_win) state_d = PRI_INSTR;
            default:   state_d = PRI_INSTR;
        endcase
        pend_instr_d = instr_win;
        pend_data_d  = data_win;
        pend_err_d   = (instr_win & ~instr_in_range) | (data_win & ~data_in_range);
    end

    // Response steering: out-of-range completes locally, otherwise the RAM beat goes to the owner.
    always_comb begin
        bus.instr_rvalid = 1'b0;
        bus.instr_err    = 1'b0;
        bus.instr_rdata  = 32'h0;
        bus.data_rvalid  = 1'b0;
        bus.data_err     = 1'b0;
        bus.data_rdata   = 32'h0;
        if (!rst_sys) begin
            if (pend_instr_q) begin
                if (pend_err_q) begin
                    bus.instr_rvalid = 1'b1;
                    bus.instr_err    = 1'b1;
                end else if (bus.mem_rvalid) begin
                    bus.instr_rvalid = 1'b1;
                    bus.instr_rdata  = bus.mem_rdata;
                end
            end
            if (pend_data_q) begin
                if (pend_err_q) begin
                    bus.data_rvalid = 1'b1;
                    bus.data_err    = 1'b1;
                end else if (bus.mem_rvalid) begin
                    bus.data_rvalid = 1'b1;
                    bus.data_rdata  = bus.mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q      <= PRI_INSTR;
            starve_cnt_q <= 4'd0;
            pend_instr_q <= 1'b0;
            pend_data_q  <= 1'b0;
            pend_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            pend_instr_q <= pend_instr_d;
            pend_data_q  <= pend_data_d;
            pend_err_q   <= pend_err_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] instr_gnt_cnt_q, data_gnt_cnt_q, conflict_cnt_q;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            instr_gnt_cnt_q <= 32'h0;
            data_gnt_cnt_q  <= 32'h0;
            conflict_cnt_q  <= 32'h0;
        end else begin
            if (instr_win) instr_gnt_cnt_q <= instr_gnt_cnt_q + 32'd1;
            if (data_win) data_gnt_cnt_q <= data_gnt_cnt_q + 32'd1;
            if (bus.instr_req && bus.data_req) conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign instr_gnt_cnt = instr_gnt_cnt_q;
    assign data_gnt_cnt  = data_gnt_cnt_q;
    assign conflict_cnt  = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomized bench for ibex_mem_arbiter: RAM responder, behavioural reference model and directed pins.
module tb_ibex_mem_arbiter;

    localparam logic [31:0] MEM_START = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE  = 32'd65536;
    localparam int          LIMIT     = 4;

    logic clk_sys = 1'b0;
    logic rst_sys;
    always #5 clk_sys = ~clk_sys;

    ibex_mem_arbiter_if bus();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] instr_gnt_cnt, data_gnt_cnt, conflict_cnt;
`endif

    ibex_mem_arbiter #(
        .MEM_START   (MEM_START),
        .MEM_SIZE    (65536),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_sys(clk_sys),
        .rst_sys(rst_sys),
        .bus    (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .instr_gnt_cnt(instr_gnt_cnt),
        .data_gnt_cnt (data_gnt_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic mid();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk_sys);
        #1;
    endtask

    // RAM contents: unwritten words read as A5A5 followed by the low half of their address
    logic [31:0] ram [int unsigned];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        int unsigned w;
        w = {a[31:2], 2'b00};
        if (ram.exists(w)) return ram[w];
        return {16'hA5A5, a[15:2], 2'b00};
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a - MEM_START) < MEM_SIZE;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a = a % MEM_SIZE;
        else if (a < MEM_SIZE) a = a + MEM_SIZE;
        return {a[31:2], 2'b00};
    endfunction

    // RAM responder: answers exactly one cycle after mem_req, occasionally emits an ownerless beat
    always begin : ram_proc
        logic        nv;
        logic [31:0] nd, cur;
        @(negedge clk_sys);
        nv = bus.mem_req;
        nd = $urandom;
        if (bus.mem_req) begin
            cur = ram_rd(bus.mem_addr);
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                ram[{bus.mem_addr[31:2], 2'b00}] = cur;
            end else begin
                nd = cur;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            nv = 1'b1;
        end
        @(posedge clk_sys);
        #1;
        bus.mem_rvalid = nv;
        bus.mem_rdata  = nd;
    end

    // Reference model: starvation count, priority flag and one pending owner (0 none, 1 instr, 2 data)
    int          m_starve = 0;
    bit          m_dprio  = 1'b0;
    int          m_owner  = 0;
    bit          m_err    = 1'b0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] m_icnt = 32'h0, m_dcnt = 32'h0, m_ccnt = 32'h0;
`endif

    always @(negedge clk_sys) begin : model_chk
        bit          ig, dg, irv, drv, ereq, ewr;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        if (rst_sys) begin
            chkb("rst_instr_gnt", bus.instr_gnt, 1'b0);
            chkb("rst_data_gnt", bus.data_gnt, 1'b0);
            chkb("rst_instr_rvalid", bus.instr_rvalid, 1'b0);
            chkb("rst_data_rvalid", bus.data_rvalid, 1'b0);
            chkb("rst_mem_req", bus.mem_req, 1'b0);
            chk("rst_mem_addr", bus.mem_addr, 32'h0);
            m_starve = 0;
            m_dprio  = 1'b0;
            m_owner  = 0;
            m_err    = 1'b0;
`ifdef ARB_PERF_CNT_EN
            m_icnt = 32'h0;
            m_dcnt = 32'h0;
            m_ccnt = 32'h0;
`endif
        end else begin
            dg = bus.data_req && (m_dprio || !bus.instr_req);
            ig = bus.instr_req && !dg;
            ereq = 1'b0; ewr = 1'b0; ebe = 4'h0; ea = 32'h0; ewd = 32'h0;
            if (ig && in_rng(bus.instr_addr)) begin
                ereq = 1'b1;
                ea   = bus.instr_addr;
            end else if (dg && in_rng(bus.data_addr)) begin
                ereq = 1'b1;
                ewr  = bus.data_we;
                ebe  = bus.data_be;
                ea   = bus.data_addr;
                ewd  = bus.data_wdata;
            end
            chkb("instr_gnt", bus.instr_gnt, ig);
            chkb("data_gnt", bus.data_gnt, dg);
            chkb("mem_req", bus.mem_req, ereq);
            chkb("mem_write", bus.mem_write, ewr);
            chk("mem_be", 32'(bus.mem_be), 32'(ebe));
            chk("mem_addr", bus.mem_addr, ea);
            chk("mem_wdata", bus.mem_wdata, ewd);

            irv = (m_owner == 1) && (m_err || bus.mem_rvalid);
            drv = (m_owner == 2) && (m_err || bus.mem_rvalid);
            chkb("instr_rvalid", bus.instr_rvalid, irv);
            chkb("data_rvalid", bus.data_rvalid, drv);
            if (irv) begin
                chkb("instr_err", bus.instr_err, m_err);
                chk("instr_rdata", bus.instr_rdata, m_err ? 32'h0 : bus.mem_rdata);
            end
            if (drv) begin
                chkb("data_err", bus.data_err, m_err);
                chk("data_rdata", bus.data_rdata, m_err ? 32'h0 : bus.mem_rdata);
            end
`ifdef ARB_PERF_CNT_EN
            chk("instr_gnt_cnt", instr_gnt_cnt, m_icnt);
            chk("data_gnt_cnt", data_gnt_cnt, m_dcnt);
            chk("conflict_cnt", conflict_cnt, m_ccnt);
            m_icnt = m_icnt + 32'(ig);
            m_dcnt = m_dcnt + 32'(dg);
            m_ccnt = m_ccnt + 32'(bus.instr_req && bus.data_req);
`endif
            if (!bus.data_req || dg) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (dg) m_dprio = 1'b0;
            else if (m_starve == LIMIT) m_dprio = 1'b1;
            m_owner = ig ? 1 : (dg ? 2 : 0);
            m_err   = ig ? !in_rng(bus.instr_addr) : (dg ? !in_rng(bus.data_addr) : 1'b0);
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ig_p, dg_p;
        rst_sys        = 1'b1;
        bus.instr_req  = 1'b0;
        bus.instr_addr = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_be    = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (3) @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;

        // instr read alone
        bus.instr_req = 1'b1; bus.instr_addr = 32'h100;
        mid();
        chkb("t1_gnt", bus.instr_gnt, 1'b1);
        chkb("t1_mem_req", bus.mem_req, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 32'h100);
        nxt();
        bus.instr_req = 1'b0;
        mid();
        chkb("t1_rvalid", bus.instr_rvalid, 1'b1);
        chk("t1_rdata", bus.instr_rdata, 32'hA5A5_0100);
        nxt();

        // data partial write, then read back
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_be = 4'b0011;
        bus.data_addr = 32'h200; bus.data_wdata = 32'hDEAD_BEEF;
        mid();
        chkb("t2_gnt", bus.data_gnt, 1'b1);
        chkb("t2_mem_write", bus.mem_write, 1'b1);
        chk("t2_mem_be", 32'(bus.mem_be), 32'h3);
        nxt();
        bus.data_req = 1'b0;
        mid();
        chkb("t2_rvalid", bus.data_rvalid, 1'b1);
        chkb("t2_err", bus.data_err, 1'b0);
        nxt();
        bus.data_req = 1'b1; bus.data_we = 1'b0;
        nxt();
        bus.data_req = 1'b0;
        mid();
        chk("t2_readback", bus.data_rdata, 32'hA5A5_BEEF);
        nxt();

        // out-of-range data read
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h0001_0000;
        mid();
        chkb("t4_gnt", bus.data_gnt, 1'b1);
        chkb("t4_mem_req", bus.mem_req, 1'b0);
        nxt();
        bus.data_req = 1'b0;
        mid();
        chkb("t4_rvalid", bus.data_rvalid, 1'b1);
        chkb("t4_err", bus.data_err, 1'b1);
        chk("t4_rdata", bus.data_rdata, 32'h0);
        nxt();

        // both held: four instr grants then one data grant, repeating
        bus.instr_req = 1'b1; bus.instr_addr = 32'h40;
        bus.data_req = 1'b1; bus.data_addr = 32'h80;
        for (int c = 0; c < 10; c++) begin
            mid();
            chkb("t3_instr_gnt", bus.instr_gnt, (c % 5) != 4);
            chkb("t3_data_gnt", bus.data_gnt, (c % 5) == 4);
            nxt();
        end

        // reset after an instr grant with data already partly starved
        bus.instr_addr = 32'h300; bus.data_addr = 32'h400;
        nxt(); nxt(); nxt();
        rst_sys = 1'b1;
        mid();
        chkb("t5_rvalid", bus.instr_rvalid, 1'b0);
        chkb("t5_gnt", bus.instr_gnt, 1'b0);
        chkb("t5_mem_req", bus.mem_req, 1'b0);
        nxt();
        rst_sys = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mid();
            if (c == 0) chkb("t5_post_rvalid", bus.instr_rvalid, 1'b0);
            chkb("t5_data_gnt", bus.data_gnt, c == 4);
            nxt();
        end
        bus.instr_req = 1'b0; bus.data_req = 1'b0;

`ifdef ARB_PERF_CNT_EN
        rst_sys = 1'b1;
        nxt();
        rst_sys = 1'b0;
        bus.instr_req = 1'b1; bus.data_req = 1'b1;
        nxt(); nxt();
        bus.instr_req = 1'b0;
        nxt();
        bus.instr_req = 1'b1; bus.data_req = 1'b0;
        nxt();
        bus.instr_req = 1'b0; bus.data_req = 1'b1;
        nxt();
        bus.data_req = 1'b0;
        mid();
        chk("t6_instr_cnt", instr_gnt_cnt, 32'd3);
        chk("t6_data_cnt", data_gnt_cnt, 32'd2);
        chk("t6_conflict_cnt", conflict_cnt, 32'd2);
        nxt();
`endif

        // randomized traffic; requests are held until granted
        ig_p = 1'b0; dg_p = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!bus.instr_req || ig_p) begin
                bus.instr_req  = $urandom_range(0, 3) != 0;
                bus.instr_addr = rnd_addr();
            end
            if (!bus.data_req || dg_p) begin
                bus.data_req   = $urandom_range(0, 2) != 0;
                bus.data_we    = 1'($urandom_range(0, 1));
                bus.data_be    = 4'($urandom);
                bus.data_addr  = rnd_addr();
                bus.data_wdata = $urandom;
            end
            rst_sys = $urandom_range(0, 299) == 0;
            mid();
            ig_p = bus.instr_gnt;
            dg_p = bus.data_gnt;
            nxt();
        end

        rst_sys = 1'b0;
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        repeat (3) nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
